// File: rtl/gcd_4bit.sv
// gcd_4bit: 4-bit greatest-common-divisor FSMD using repeated subtraction.
// One subtraction step per clock in CALC; result is registered on entry to
// DONE and held until the next result (or reset).
module gcd_4bit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       go_i,
    output logic [3:0] d_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [3:0] x_r;
    logic [3:0] y_r;

    // Comparison and both subtraction results, all available in the same cycle
    logic       x_zero;
    logic       y_zero;
    logic       xy_equal;
    logic       x_greater;
    logic [3:0] x_minus_y;
    logic [3:0] y_minus_x;

    // Datapath compare/subtract for the current operands
    always_comb begin
        x_zero    = (x_r == 4'd0);
        y_zero    = (y_r == 4'd0);
        xy_equal  = (x_r == y_r);
        x_greater = (x_r > y_r);
        x_minus_y = x_r - y_r;
        y_minus_x = y_r - x_r;
    end

    // Controller and datapath registers; reset aborts any computation at once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
            x_r       <= 4'd0;
            y_r       <= 4'd0;
            d_o       <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go_i) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // Operands are sampled here only; later input changes are ignored
                    x_r       <= x_i;
                    y_r       <= y_i;
                    state_reg <= CALC;
                end
                CALC: begin
                    // Zero checks come first so gcd(0,n)=n and gcd(0,0)=0 terminate
                    if (x_zero) begin
                        d_o       <= y_r;
                        state_reg <= DONE;
                    end else if (y_zero) begin
                        d_o       <= x_r;
                        state_reg <= DONE;
                    end else if (xy_equal) begin
                        d_o       <= x_r;
                        state_reg <= DONE;
                    end else if (x_greater) begin
                        x_r <= x_minus_y;
                    end else begin
                        y_r <= y_minus_x;
                    end
                end
                DONE: begin
                    // Wait for go_i to drop so a held request runs only once
                    if (!go_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_4bit.sv
// Directed bench for gcd_4bit: expected results are pushed to a scoreboard
// queue when a request is driven and popped at the cycle the result is due.
module tb_gcd_4bit;

    logic       CLK;
    logic       RESET;
    logic [3:0] x_i;
    logic [3:0] y_i;
    logic       go_i;
    logic [3:0] d_o;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic [3:0] last_exp;

    gcd_4bit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .x_i   (x_i),
        .y_i   (y_i),
        .go_i  (go_i),
        .d_o   (d_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; outputs are then sampled on the falling edge
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: Euclid by remainder for the value, subtraction count for latency
    function automatic void model(input int a, input int b, output int g, output int steps);
        int u, v, t, p, q;
        u = a; v = b;
        while (v != 0) begin
            t = u % v;
            u = v;
            v = t;
        end
        g = u;
        p = a; q = b; steps = 0;
        while (p != 0 && q != 0 && p != q) begin
            if (p > q) p = p - q;
            else       q = q - p;
            steps++;
        end
    endfunction

    // Drive one request with go_i held for go_len cycles and check d_o every cycle
    task automatic run(input int a, input int b, input int go_len);
        int g, steps, lat, last, popped;
        string tag;
        model(a, b, g, steps);
        lat  = steps + 3;   // go seen, LOAD, steps, final compare
        last = (go_len > lat) ? go_len : lat;
        exp_q.push_back(g);
        tag = $sformatf("gcd(%0d,%0d)", a, b);
        x_i  = a[3:0];
        y_i  = b[3:0];
        go_i = 1'b1;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == go_len) go_i = 1'b0;
            if (k == 2) begin
                // Operands already captured; a recompute would give 7
                x_i = 4'd7;
                y_i = 4'd14;
            end
            if (k < lat) begin
                check({tag, "_hold_prev"}, d_o, last_exp);
            end else if (k == lat) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
                end else begin
                    popped = exp_q.pop_front();
                    check({tag, "_result"}, d_o, popped[3:0]);
                end
            end else begin
                check({tag, "_done_hold"}, d_o, g[3:0]);
            end
        end
        go_i = 1'b0;
        tick();
        tick();
        check({tag, "_idle_hold"}, d_o, g[3:0]);
        last_exp = g[3:0];
        $display("txn x=%0d y=%0d go_len=%0d expected=%0d latency=%0d d_o=%0d", a, b, go_len, g, lat, d_o);
    endtask

    initial begin
        RESET    = 1'b0;
        x_i      = 4'd0;
        y_i      = 4'd0;
        go_i     = 1'b0;
        last_exp = 4'd0;
        #1;
        check("reset_async", d_o, 4'd0);
        @(negedge CLK);
        go_i = 1'b1;
        tick();
        tick();
        check("reset_held", d_o, 4'd0);
        go_i  = 1'b0;
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_after_reset", d_o, 4'd0);
        end

        run(8, 12, 3);
        run(3, 8, 1);
        run(15, 10, 2);
        run(9, 9, 1);

        // Abort a long computation mid-CALC
        x_i  = 4'd15;
        y_i  = 4'd1;
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
        tick();
        tick();
        tick();
        check("pre_abort_hold", d_o, last_exp);
        RESET = 1'b0;
        #1;
        check("abort_async", d_o, 4'd0);
        @(negedge CLK);
        RESET    = 1'b1;
        last_exp = 4'd0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_after_abort", d_o, 4'd0);
        end
        $display("txn reset mid-CALC x=15 y=1 d_o=%0d", d_o);

        run(0, 6, 1);
        run(0, 0, 1);
        run(6, 0, 1);
        run(15, 1, 2);
        run(8, 12, 20);

        // go_i already high when reset is released
        RESET = 1'b0;
        go_i  = 1'b1;
        #1;
        check("reset_with_go", d_o, 4'd0);
        last_exp = 4'd0;
        @(negedge CLK);
        RESET = 1'b1;
        run(5, 10, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
